// File: rtl/cg_phase_sequencer.sv
// rtl/cg_phase_sequencer.sv - phase sequencer for an iterative conjugate-gradient solve
//
// Walks one solve through COPY (R -> Rprev), MXV, PAP, XRU, RR and CHECK,
// looping through PUPD until the residual converges or the iteration limit
// is reached, then pulses finish_all from DONE.
//
// Ports:
//   clk, reset             clock and asynchronous active-low reset
//   start_solve, abort     solve request / abandon
//   total, max_iter        copy length in row groups / iteration limit
//   mXv_finish, vXv_finish, upd_finish, converged   unit handshakes
//   reset_mXv1, reset_vXv1, upd_start               one-cycle unit pulses
//   memoryR_read_address, memoryRprev_we, rprev_write_address   copy port
//   state, iteration, busy, finish_all, timeout     status
module cg_phase_sequencer #(
  parameter int memory_height = 1000,
  parameter int address_width = $clog2(memory_height) + 1,
  parameter int iter_width    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_solve,
  input  logic                     abort,
  input  logic [31:0]              total,
  input  logic [iter_width-1:0]    max_iter,
  input  logic                     mXv_finish,
  input  logic                     vXv_finish,
  input  logic                     upd_finish,
  input  logic                     converged,
  output logic                     reset_mXv1,
  output logic                     reset_vXv1,
  output logic                     upd_start,
  output logic [address_width-1:0] memoryR_read_address,
  output logic                     memoryRprev_we,
  output logic [address_width-1:0] rprev_write_address,
  output logic [3:0]               state,
  output logic [iter_width-1:0]    iteration,
  output logic                     busy,
  output logic                     finish_all,
  output logic                     timeout
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_COPY  = 4'd1,
    S_MXV   = 4'd2,
    S_PAP   = 4'd3,
    S_XRU   = 4'd4,
    S_RR    = 4'd5,
    S_CHECK = 4'd6,
    S_PUPD  = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t      st;
  logic [31:0] cnt;        // index of the R address currently being driven
  logic [31:0] total_q;    // copy length captured at start so a changing input cannot derail COPY
  logic [31:0] cnt_inc;
  logic        conv_flag;

  assign cnt_inc = cnt + 32'd1;
  assign state   = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st                   <= S_IDLE;
      cnt                  <= '0;
      total_q              <= '0;
      conv_flag            <= 1'b0;
      reset_mXv1           <= 1'b0;
      reset_vXv1           <= 1'b0;
      upd_start            <= 1'b0;
      memoryR_read_address <= '0;
      memoryRprev_we       <= 1'b0;
      rprev_write_address  <= '0;
      iteration            <= '0;
      busy                 <= 1'b0;
      finish_all           <= 1'b0;
      timeout              <= 1'b0;
    end else begin
      // Pulses default low so each lasts exactly the first cycle of its state.
      reset_mXv1 <= 1'b0;
      reset_vXv1 <= 1'b0;
      upd_start  <= 1'b0;
      finish_all <= 1'b0;

      if (abort && st != S_IDLE) begin
        st             <= S_IDLE;
        busy           <= 1'b0;
        memoryRprev_we <= 1'b0;
      end else begin
        case (st)
          S_IDLE: begin
            memoryRprev_we <= 1'b0;
            if (start_solve && total != 32'd0) begin
              st                   <= S_COPY;
              busy                 <= 1'b1;
              total_q              <= total;
              cnt                  <= '0;
              memoryR_read_address <= '0;
              iteration            <= '0;
              timeout              <= 1'b0;
              conv_flag            <= 1'b0;
            end
          end

          S_COPY: begin
            if (cnt < total_q) begin
              // Read data for address cnt arrives next cycle; write it then.
              memoryRprev_we      <= 1'b1;
              rprev_write_address <= cnt[address_width-1:0];
              cnt                 <= cnt_inc;
              if (cnt_inc < total_q) begin
                memoryR_read_address <= cnt_inc[address_width-1:0];
              end
            end else begin
              memoryRprev_we <= 1'b0;
              st             <= S_MXV;
              reset_mXv1     <= 1'b1;
            end
          end

          // In each compute state the pulse register doubles as the
          // "first cycle" marker, so a finish seen alongside it is ignored.
          S_MXV: begin
            if (!reset_mXv1 && mXv_finish) begin
              st         <= S_PAP;
              reset_vXv1 <= 1'b1;
            end
          end

          S_PAP: begin
            if (!reset_vXv1 && vXv_finish) begin
              st        <= S_XRU;
              upd_start <= 1'b1;
            end
          end

          S_XRU: begin
            if (!upd_start && upd_finish) begin
              st         <= S_RR;
              reset_vXv1 <= 1'b1;
            end
          end

          S_RR: begin
            if (!reset_vXv1 && vXv_finish) begin
              st        <= S_CHECK;
              conv_flag <= converged;
              if (iteration != {iter_width{1'b1}}) begin
                iteration <= iteration + 1'b1;
              end
            end
          end

          S_CHECK: begin
            if (conv_flag) begin
              st         <= S_DONE;
              finish_all <= 1'b1;
              timeout    <= 1'b0;
            end else if (iteration >= max_iter) begin
              st         <= S_DONE;
              finish_all <= 1'b1;
              timeout    <= 1'b1;
            end else begin
              st        <= S_PUPD;
              upd_start <= 1'b1;
            end
          end

          S_PUPD: begin
            if (!upd_start && upd_finish) begin
              st                   <= S_COPY;
              cnt                  <= '0;
              memoryR_read_address <= '0;
            end
          end

          S_DONE: begin
            st   <= S_IDLE;
            busy <= 1'b0;
          end

          default: begin
            st   <= S_IDLE;
            busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/cg_phase_sequencer.md
CG_PHASE_SEQUENCER -- requirements
Module: cg_phase_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
  memory_height, 1000, depth of R/Rprev memories in row groups.
  address_width, $clog2(memory_height)+1, width of memory addresses.
  iter_width, 16, width of the iteration counter and limit.
REQ-002 Ports SHALL be (name direction width meaning), clock and reset first:
  clk  in  1  single clock; all state changes on its rising edge.
  reset  in  1  asynchronous, active-low reset.
  start_solve  in  1  one-cycle request to begin a solve.
  abort  in  1  synchronous abandon of the current solve.
  total  in  32  number of row groups (R copy length).
  max_iter  in  iter_width  iteration limit.
  mXv_finish  in  1  A*p pass complete.
  vXv_finish  in  1  dot-product pass complete.
  upd_finish  in  1  vector-update pass complete.
  converged  in  1  residual below threshold; valid with vXv_finish in RR.
  reset_mXv1  out  1  one-cycle restart pulse to the matrix-vector unit.
  reset_vXv1  out  1  one-cycle restart pulse to the dot-product unit.
  upd_start  out  1  one-cycle start pulse to the update unit.
  memoryR_read_address  out  address_width  R read address during COPY.
  memoryRprev_we  out  1  rKold_prev write enable.
  rprev_write_address  out  address_width  rKold_prev write address.
  state  out  4  current state code.
  iteration  out  iter_width  completed iterations.
  busy  out  1  high in every state except IDLE.
  finish_all  out  1  one-cycle end-of-solve pulse.
  timeout  out  1  solve ended on the limit; held until the next start.

Function
REQ-003 The state codes SHALL be: IDLE=0, COPY=1, MXV=2, PAP=3, XRU=4, RR=5, CHECK=6, PUPD=7, DONE=8.
REQ-004 The state transition order SHALL be IDLE->COPY->MXV->PAP->XRU->RR->CHECK->{PUPD->COPY | DONE}->IDLE.
REQ-005 IDLE SHALL move to COPY on start_solve=1 with total!=0; start_solve SHALL be ignored when total==0 or busy=1.
REQ-006 On entering COPY, a counter SHALL be set to 0, and memoryR_read_address SHALL equal k in the k-th COPY cycle, for k=0..total-1.
REQ-007 memoryRprev_we SHALL be 1 with rprev_write_address=k exactly one cycle after address k is driven (one-cycle read latency).
REQ-008 COPY SHALL exit to MXV in the cycle after the final write enable, i.e. COPY lasts total+1 cycles.
REQ-009 In the first cycle of MXV, reset_mXv1=1; in the first cycle of PAP and of RR, reset_vXv1=1; in the first cycle of XRU and of PUPD, upd_start=1; each pulse SHALL be exactly one cycle long.
REQ-010 A compute state SHALL accept its finish input (mXv_finish for MXV, vXv_finish for PAP/RR, upd_finish for XRU/PUPD) only from the cycle after its pulse, and SHALL transition on the next edge.
REQ-011 Finish inputs SHALL be ignored in every other state and in the pulse cycle.
REQ-012 When vXv_finish is accepted in RR, converged SHALL be latched into conv_flag, and iteration SHALL increment by 1, saturating at all-ones.
REQ-013 CHECK SHALL last one cycle, with a fixed priority order:
  conv_flag=1 -> DONE, timeout=0;
  else iteration>=max_iter -> DONE, timeout=1;
  else -> PUPD.
  max_iter=0 therefore yields exactly one iteration.
REQ-014 DONE SHALL last one cycle with finish_all=1, then go to IDLE; iteration and timeout SHALL hold until the next accepted start_solve, which clears both and conv_flag.
REQ-015 abort=1 in any non-IDLE state SHALL force IDLE on the next edge:
  no finish_all;
  pulses and memoryRprev_we deasserted that cycle;
  iteration held.
  abort SHALL have priority over finish inputs and start_solve.
REQ-016 busy SHALL be a registered decode, equal to (state!=IDLE).
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 While reset=0, asynchronously: state=IDLE, all pulses, memoryRprev_we, busy, finish_all and timeout = 0; addresses = 0; iteration = 0; conv_flag = 0.
REQ-019 Reset asserted mid-solve SHALL abandon the solve without a finish_all pulse.
REQ-020 The first state change after reset release SHALL require a start_solve sampled on a rising edge with reset=1.

Verification
REQ-021 Copy sweep: total=3, start_solve -> addresses 0,1,2 on cycles 1-3; memoryRprev_we with write addresses 0,1,2 on cycles 2-4; state=MXV with reset_mXv1=1 on cycle 5.
REQ-022 Converged solve: converged=1 at the first RR vXv_finish -> CHECK then DONE; finish_all single pulse; iteration=1; timeout=0; no PUPD entry.
REQ-023 Limit: max_iter=2, converged=0 -> two full loops, DONE, timeout=1, iteration=2; max_iter=0 -> one loop then timeout=1.
REQ-024 Handshake filtering: mXv_finish held high during the pulse cycle and during PAP -> ignored; state advances only on the finish asserted in the correct post-pulse window.
REQ-025 Abort/reset: abort in PAP simultaneous with vXv_finish -> IDLE next cycle, no finish_all; reset=0 mid-COPY -> all outputs 0 immediately, no further memoryRprev_we.
REQ-026 Ignored starts: start_solve with total=0 -> remains IDLE; start_solve while busy -> no restart, sequence unchanged.
